// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: freeze, redirect requests, fetch handshake and status.
// misalign_o exists only when PC_GEN_ALIGN_CHK_EN is defined.
interface pc_gen_if #(
    parameter int WORD_SIZE_P = 16,
    parameter int NUM_REDIR_P = 3,
    parameter int CNT_W_P     = 8
);
    logic                                 hold_i;
    logic [NUM_REDIR_P-1:0]               redirect_v_i;
    logic [NUM_REDIR_P*WORD_SIZE_P-1:0]   redirect_pc_i;
    logic                                 fetch_ready_i;
    logic [WORD_SIZE_P-1:0]               pc_o;
    logic                                 pc_v_o;
    logic                                 redirect_taken_o;
    logic                                 pending_o;
    logic [CNT_W_P-1:0]                   redirect_cnt_o;
`ifdef PC_GEN_ALIGN_CHK_EN
    logic                                 misalign_o;
`endif

    modport master (
        output hold_i, redirect_v_i, redirect_pc_i, fetch_ready_i,
        input  pc_o, pc_v_o, redirect_taken_o, pending_o, redirect_cnt_o
`ifdef PC_GEN_ALIGN_CHK_EN
        , input misalign_o
`endif
    );

    modport slave (
        input  hold_i, redirect_v_i, redirect_pc_i, fetch_ready_i,
        output pc_o, pc_v_o, redirect_taken_o, pending_o, redirect_cnt_o
`ifdef PC_GEN_ALIGN_CHK_EN
        , output misalign_o
`endif
    );
endinterface

// File: rtl/pc_gen.sv
// Registered fetch PC generator with prioritised redirects and a one-entry redirect buffer
// used while frozen. Optional target alignment check: PC_GEN_ALIGN_CHK_EN.
module pc_gen #(
    parameter int                     WORD_SIZE_P = 16,
    parameter int                     STEP_P      = 2,
    parameter int                     NUM_REDIR_P = 3,
    parameter logic [WORD_SIZE_P-1:0] RESET_VEC_P = '0,
    parameter int                     CNT_W_P     = 8
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    pc_gen_if.slave  bus
);
    localparam int IDX_W = (NUM_REDIR_P > 1) ? $clog2(NUM_REDIR_P) : 1;
    localparam logic [CNT_W_P-1:0] CNT_MAX = '1;
`ifdef PC_GEN_ALIGN_CHK_EN
    localparam logic [WORD_SIZE_P-1:0] ALIGN_MASK = WORD_SIZE_P'(STEP_P - 1);
`endif

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t                  state_r, state_n;
    logic [WORD_SIZE_P-1:0]  pc_r, pc_n, pend_pc_r, pend_pc_n;
    logic [WORD_SIZE_P-1:0]  sel_pc, apply_pc, load_pc;
    logic [IDX_W-1:0]        sel, pend_idx_r, pend_idx_n;
    logic                    any_redir, sel_beats_pend, pc_v, accept;
    logic                    apply, incr, taken_r, misalign;
    logic [CNT_W_P-1:0]      cnt_r;
`ifdef PC_GEN_ALIGN_CHK_EN
    logic                    misalign_r;
`endif

    // Lowest set index wins, so scan from the top down and let lower indices overwrite.
    always_comb begin
        sel = '0;
        for (int k = NUM_REDIR_P - 1; k >= 0; k--) begin
            if (bus.redirect_v_i[k]) sel = IDX_W'(k);
        end
    end

    assign any_redir      = |bus.redirect_v_i;
    assign sel_pc         = bus.redirect_pc_i[sel*WORD_SIZE_P +: WORD_SIZE_P];
    assign sel_beats_pend = any_redir && (sel < pend_idx_r);
    assign pc_v           = (state_r == RUN) && !bus.hold_i;
    assign accept         = pc_v && bus.fetch_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= BOOT;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n    = state_r;
        pend_pc_n  = pend_pc_r;
        pend_idx_n = pend_idx_r;
        apply      = 1'b0;
        incr       = 1'b0;
        apply_pc   = sel_pc;
        case (state_r)
            BOOT: begin
                if (!bus.hold_i) begin
                    state_n = RUN;
                    apply   = any_redir;
                end
            end
            RUN: begin
                if (bus.hold_i) begin
                    if (any_redir) begin
                        state_n    = PEND;
                        pend_pc_n  = sel_pc;
                        pend_idx_n = sel;
                    end
                end else if (any_redir) begin
                    apply = 1'b1;
                end else begin
                    incr = accept;
                end
            end
            PEND: begin
                // A strictly higher-priority live request beats the buffered one, even on release.
                if (!bus.hold_i) begin
                    state_n  = RUN;
                    apply    = 1'b1;
                    apply_pc = sel_beats_pend ? sel_pc : pend_pc_r;
                end else if (sel_beats_pend) begin
                    pend_pc_n  = sel_pc;
                    pend_idx_n = sel;
                end
            end
            default: state_n = BOOT;
        endcase
    end

`ifdef PC_GEN_ALIGN_CHK_EN
    assign load_pc  = apply_pc & ~ALIGN_MASK;
    assign misalign = apply && |(apply_pc & ALIGN_MASK);
`else
    assign load_pc  = apply_pc;
    assign misalign = 1'b0;
`endif

    always_comb begin
        pc_n = pc_r;
        if (apply)     pc_n = load_pc;
        else if (incr) pc_n = pc_r + WORD_SIZE_P'(STEP_P);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_r       <= RESET_VEC_P;
            pend_pc_r  <= '0;
            pend_idx_r <= '0;
            taken_r    <= 1'b0;
            cnt_r      <= '0;
        end else begin
            pc_r       <= pc_n;
            pend_pc_r  <= pend_pc_n;
            pend_idx_r <= pend_idx_n;
            taken_r    <= apply;
            if (apply && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + 1'b1;
        end
    end

`ifdef PC_GEN_ALIGN_CHK_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) misalign_r <= 1'b0;
        else            misalign_r <= misalign;
    end
    assign bus.misalign_o = misalign_r;
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

    assign bus.pc_o             = pc_r;
    assign bus.pc_v_o           = pc_v;
    assign bus.redirect_taken_o = taken_r;
    assign bus.pending_o        = (state_r == PEND);
    assign bus.redirect_cnt_o   = cnt_r;
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered fetch program-counter generator; next generation of the front-end next-PC selector.
- Holds the fetch PC and offers it to the fetch stage with a valid/ready handshake.
- Arbitrates NUM_REDIR_P prioritised redirect sources (e.g. trap, mispredict, branch).
- Buffers a redirect that arrives while frozen and applies it when the freeze lifts.

Parameters:
- WORD_SIZE_P, 16: PC width in bits.
- STEP_P, 2: sequential increment in bytes.
- NUM_REDIR_P, 3: number of redirect sources; index 0 has highest priority.
- RESET_VEC_P, 0: PC value loaded at reset.
- CNT_W_P, 8: width of the applied-redirect counter.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- reset_n_i, in, 1: asynchronous active-low reset.
- hold_i, in, 1: freeze; while high, no PC update and no handshake.
- redirect_v_i, in, NUM_REDIR_P: per-source redirect request.
- redirect_pc_i, in, NUM_REDIR_P*WORD_SIZE_P: per-source target; source k occupies bits [k*W +: W].
- fetch_ready_i, in, 1: fetch stage accepts pc_o this cycle.
- pc_o, out, WORD_SIZE_P: current fetch PC.
- pc_v_o, out, 1: pc_o valid.
- redirect_taken_o, out, 1: a redirect was applied at the last edge (registered pulse).
- pending_o, out, 1: a buffered redirect is waiting.
- redirect_cnt_o, out, CNT_W_P: count of applied redirects, saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-hold or with a redirect pending):
  - pc_r=RESET_VEC_P, state=BOOT, pc_v_o=0, pending cleared, redirect_taken_o=0, redirect_cnt_o=0.
- States:
  - BOOT: pc_v_o=0. Next edge goes to RUN unless hold_i=1.
  - RUN: pc_v_o=~hold_i.
  - PEND: pc_v_o=0; a buffered redirect exists and pending_o=1.
- Selection: sel = lowest index k with redirect_v_i[k]=1; any_redir = |redirect_v_i.
- accept = pc_v_o & fetch_ready_i. Because pc_v_o is 0 while hold_i=1, accept is 0 under hold.
- RUN, hold_i=0:
  - any_redir: pc_r <= target[sel]; redirect_taken_o<=1; counter+1. This overrides accept; the current PC is still reported as accepted if fetch_ready_i=1.
  - else if accept: pc_r <= pc_r+STEP_P, modulo 2^WORD_SIZE_P (FFFE+2 -> 0000).
  - else: hold pc_r.
- RUN, hold_i=1: pc_r unchanged.
  - any_redir: capture target[sel] and index sel into pend_pc/pend_idx, go to PEND.
- PEND:
  - A new redirect with index < pend_idx replaces the buffer. Equal or lower priority is ignored.
  - On the first cycle with hold_i=0: pc_r <= pend_pc, or target[sel] if a live redirect with sel < pend_idx is present that same cycle. Pulse redirect_taken_o, counter+1, return to RUN.
  - pc_v_o is 1 on the cycle after that edge.
- BOOT, any_redir with hold_i=0: apply as in RUN, then go to RUN.
- redirect_taken_o is 0 on every cycle with no application.
- Counter saturates at 2^CNT_W_P-1; no wrap.

Optional Feature:
- Macro: PC_GEN_ALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - Any applied target with bits [log2(STEP_P)-1:0] != 0 has those bits forced to 0 in pc_r.
  - misalign_o pulses for one cycle alongside redirect_taken_o.
- Undefined: no port; targets are loaded unmodified.

Test Plan:
- Reset then run: reset_n_i low 3 cycles, RESET_VEC_P=0x0100, fetch_ready_i=1 -> pc_v_o=0 for the first cycle after deassert, then pc_o=0x0100, 0x0102, 0x0104 on consecutive cycles.
- Backpressure and wrap: pc_r=0xFFFE, fetch_ready_i=0 for 2 cycles -> pc_o stays 0xFFFE; then ready=1 -> next pc_o=0x0000.
- Priority: redirect_v_i=3'b110 with targets src1=0x2000, src2=0x3000 -> next pc_o=0x2000, redirect_taken_o=1, redirect_cnt_o=1.
- Buffer under hold:
  - hold_i=1; src2=0x3000 arrives, then src0=0x0800 two cycles later.
  - pending_o=1 throughout and pc_v_o=0.
  - On hold drop -> pc_o=0x0800, counter +1 (not +2).
- Reset mid-pend: pending_o=1, assert reset_n_i=0 asynchronously -> pending_o=0, pc_o=RESET_VEC_P immediately, without waiting for a clock edge.
- With PC_GEN_ALIGN_CHK_EN, STEP_P=2: redirect to 0x1235 -> pc_o=0x1234, misalign_o pulses once. Saturation: CNT_W_P=2, 5 redirects -> redirect_cnt_o=3.
